// File: rtl/mtx_pkg.sv
// Shared constants and state encoding for the matrix transpose stream.
// Imported by the interface, the bank and the top.
package mtx_pkg;

  localparam int MTX_N_DEF = 5;
  localparam int MTX_W_DEF = 8;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } mtx_state_t;

endpackage

// File: rtl/matrix_transpose_stream_if.sv
// Row-in / beat-out handshake bundle for matrix_transpose_stream.
// master = traffic source/sink side, slave = the transpose block.
interface matrix_transpose_stream_if
  import mtx_pkg::*;
#(
  parameter int N = MTX_N_DEF,
  parameter int W = MTX_W_DEF
) ();

  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_row;
  logic           tr_en;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_col;
  logic           out_last;

  modport master (
    output in_valid, in_row, tr_en, out_ready,
    input  in_ready, out_valid, out_col, out_last
  );

  modport slave (
    input  in_valid, in_row, tr_en, out_ready,
    output in_ready, out_valid, out_col, out_last
  );

endinterface

// File: rtl/mtx_bank.sv
// N x N element store: one row written per cycle, one beat read combinationally,
// either a stored row (rd_tr=0) or a column across all rows (rd_tr=1).
module mtx_bank
  import mtx_pkg::*;
#(
  parameter int N  = MTX_N_DEF,
  parameter int W  = MTX_W_DEF,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           wr_en,
  input  logic [IW-1:0]  wr_idx,
  input  logic [N*W-1:0] wr_row,
  input  logic [IW-1:0]  rd_idx,
  input  logic           rd_tr,
  output logic [N*W-1:0] rd_data
);

  logic [W-1:0] mem_q [N][N];
  logic [W-1:0] mem_d [N][N];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int c = 0; c < N; c++) begin
        mem_d[wr_idx][c] = wr_row[(N-c)*W-1 -: W];
      end
    end
  end

  // Payload only; control state guarantees nothing is read before it is written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < N; c++) begin
      rd_data[(N-c)*W-1 -: W] = rd_tr ? mem_q[c][rd_idx] : mem_q[rd_idx][c];
    end
  end

endmodule

// File: rtl/matrix_transpose_stream.sv
// Streams N rows in, then N beats out (transposed or passed through per matrix).
// Optional macro MTX_TRANS_PINGPONG_EN adds a second bank so load and drain overlap.
module matrix_transpose_stream
  import mtx_pkg::*;
#(
  parameter int N = MTX_N_DEF,
  parameter int W = MTX_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  matrix_transpose_stream_if.slave   bus,
  output logic                       busy
);

  localparam int            IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic           in_hs;
  logic           out_hs;
  logic [IW-1:0]  row_cnt_q, row_cnt_d;
  logic [IW-1:0]  beat_cnt_q, beat_cnt_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic [N*W-1:0] rd_data;

  assign in_hs         = bus.in_valid & bus.in_ready;
  assign out_hs        = out_valid_q & bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_col   = out_valid_q ? rd_data : '0;

`ifdef MTX_TRANS_PINGPONG_EN
  mtx_state_t     bst_q [2];
  mtx_state_t     bst_d [2];
  logic           btr_q [2];
  logic           btr_d [2];
  logic           wr_sel_q, wr_sel_d;
  logic           rd_sel_q, rd_sel_d;
  logic [N*W-1:0] bank_rd [2];

  assign bus.in_ready = (bst_q[wr_sel_q] == LOAD);
  assign busy = (bst_q[0] == DRAIN) | (bst_q[1] == DRAIN) | (row_cnt_q != '0);

  // wr_sel and rd_sel always point at different banks whenever both handshake.
  always_comb begin
    bst_d      = bst_q;
    btr_d      = btr_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    row_cnt_d  = row_cnt_q;
    beat_cnt_d = beat_cnt_q;
    if (in_hs) begin
      if (row_cnt_q == '0) btr_d[wr_sel_q] = bus.tr_en;
      if (row_cnt_q == LAST_IDX) begin
        row_cnt_d       = '0;
        bst_d[wr_sel_q] = DRAIN;
        wr_sel_d        = ~wr_sel_q;
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
      end
    end
    if (out_hs) begin
      if (beat_cnt_q == LAST_IDX) begin
        beat_cnt_d      = '0;
        bst_d[rd_sel_q] = LOAD;
        rd_sel_d        = ~rd_sel_q;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
    out_valid_d = (bst_d[rd_sel_d] == DRAIN);
    out_last_d  = out_valid_d && (beat_cnt_d == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bst_q[0] <= LOAD;
      bst_q[1] <= LOAD;
      btr_q[0] <= 1'b0;
      btr_q[1] <= 1'b0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      bst_q    <= bst_d;
      btr_q    <= btr_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    mtx_bank #(.N(N), .W(W), .IW(IW)) u_bank (
      .clk     (clk),
      .wr_en   (in_hs && (wr_sel_q == 1'(b))),
      .wr_idx  (row_cnt_q),
      .wr_row  (bus.in_row),
      .rd_idx  (beat_cnt_q),
      .rd_tr   (btr_q[b]),
      .rd_data (bank_rd[b])
    );
  end

  assign rd_data = bank_rd[rd_sel_q];
`else
  mtx_state_t st_q, st_d;
  logic       tr_q, tr_d;

  assign bus.in_ready = (st_q == LOAD);
  assign busy         = (st_q == DRAIN) | (row_cnt_q != '0);

  always_comb begin
    st_d        = st_q;
    tr_d        = tr_q;
    row_cnt_d   = row_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    unique case (st_q)
      LOAD: begin
        if (in_hs) begin
          if (row_cnt_q == '0) tr_d = bus.tr_en;
          if (row_cnt_q == LAST_IDX) begin
            row_cnt_d   = '0;
            beat_cnt_d  = '0;
            st_d        = DRAIN;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (beat_cnt_q == LAST_IDX) begin
            beat_cnt_d  = '0;
            st_d        = LOAD;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            out_last_d = (beat_cnt_q + 1'b1 == LAST_IDX);
          end
        end
      end
      default: st_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= LOAD;
      tr_q <= 1'b0;
    end else begin
      st_q <= st_d;
      tr_q <= tr_d;
    end
  end

  mtx_bank #(.N(N), .W(W), .IW(IW)) u_bank (
    .clk     (clk),
    .wr_en   (in_hs),
    .wr_idx  (row_cnt_q),
    .wr_row  (bus.in_row),
    .rd_idx  (beat_cnt_q),
    .rd_tr   (tr_q),
    .rd_data (rd_data)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      row_cnt_q   <= row_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_matrix_transpose_stream.sv
// Directed bench for matrix_transpose_stream (N=5, W=8): vector table plus
// hand-written stall, mid-matrix reset and back-to-back sequences.
module tb_matrix_transpose_stream;

  localparam int N = 5;
  localparam int W = 8;

`ifdef MTX_TRANS_PINGPONG_EN
  localparam logic IRDY_DRAIN = 1'b1;
  localparam int   B2B_STALLS = 0;
  localparam int   B2B_SPAN   = 9;
`else
  localparam logic IRDY_DRAIN = 1'b0;
  localparam int   B2B_STALLS = 5;
  localparam int   B2B_SPAN   = 14;
`endif

  typedef struct packed {
    logic [N-1:0][N*W-1:0] rows;
    logic                  tr;
    int                    stall_beat;
    logic [N-1:0][N*W-1:0] beats;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [4];

  matrix_transpose_stream_if #(.N(N), .W(W)) bus ();

  matrix_transpose_stream #(.N(N), .W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [39:0] r0, r1, r2, r3, r4,
                              input logic [39:0] b0, b1, b2, b3, b4,
                              input logic tr, input int stall);
    vec_t v;
    v.rows = {r4, r3, r2, r1, r0};
    v.beats = {b4, b3, b2, b1, b0};
    v.tr = tr;
    v.stall_beat = stall;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rows(input vec_t v, input int nrows, input string tag);
    int guard;
    for (int r = 0; r < nrows; r++) begin
      bus.in_valid = 1'b1;
      bus.in_row   = v.rows[r];
      bus.tr_en    = (r == 0) ? v.tr : ~v.tr;
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
        tick();
        guard++;
      end
      chk($sformatf("%s_row%0d_wait", tag, r), 64'(guard < 50), 64'd1);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_matrix(input vec_t v, input string tag);
    int guard;
    send_rows(v, N, tag);
    chk({tag, "_latency1"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_busy_drain"}, 64'(busy), 64'd1);
    for (int k = 0; k < N; k++) begin
      guard = 0;
      while (!bus.out_valid && guard < 50) begin
        tick();
        guard++;
      end
      chk($sformatf("%s_beat%0d_wait", tag, k), 64'(guard < 50), 64'd1);
      chk($sformatf("%s_beat%0d_col", tag, k), 64'(bus.out_col), 64'(v.beats[k]));
      chk($sformatf("%s_beat%0d_last", tag, k), 64'(bus.out_last), 64'(k == N - 1));
      chk($sformatf("%s_beat%0d_in_ready", tag, k), 64'(bus.in_ready), 64'(IRDY_DRAIN));
      if (k == v.stall_beat) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk($sformatf("%s_stall%0d_valid", tag, s), 64'(bus.out_valid), 64'd1);
          chk($sformatf("%s_stall%0d_col", tag, s), 64'(bus.out_col), 64'(v.beats[k]));
          chk($sformatf("%s_stall%0d_last", tag, s), 64'(bus.out_last), 64'(k == N - 1));
        end
        bus.out_ready = 1'b1;
      end
      tick();
    end
    chk({tag, "_valid_after"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int stalls;
    int first_cyc;
    int last_cyc;
    int nb;
    int cyc;
    logic [39:0] exp_b2b [10];

    vecs[0] = mk(40'h0102030405, 40'h060708090A, 40'h0B0C0D0E0F, 40'h1011121314, 40'h1516171819,
                 40'h01060B1015, 40'h02070C1116, 40'h03080D1217, 40'h04090E1318, 40'h050A0F1419,
                 1'b1, 2);
    vecs[1] = mk(40'h0102030405, 40'h060708090A, 40'h0B0C0D0E0F, 40'h1011121314, 40'h1516171819,
                 40'h0102030405, 40'h060708090A, 40'h0B0C0D0E0F, 40'h1011121314, 40'h1516171819,
                 1'b0, -1);
    vecs[2] = mk(40'h80FF7F0001, 40'h060708090A, 40'h0B0C0D0E0F, 40'h1011121314, 40'h1516171819,
                 40'h80060B1015, 40'hFF070C1116, 40'h7F080D1217, 40'h00090E1318, 40'h010A0F1419,
                 1'b1, -1);
    vecs[3] = mk(40'hA0A1A2A3A4, 40'hB0B1B2B3B4, 40'hC0C1C2C3C4, 40'hD0D1D2D3D4, 40'hE0E1E2E3E4,
                 40'hA0B0C0D0E0, 40'hA1B1C1D1E1, 40'hA2B2C2D2E2, 40'hA3B3C3D3E3, 40'hA4B4C4D4E4,
                 1'b1, 0);

    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.tr_en     = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_out_col", 64'(bus.out_col), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", 64'(bus.in_ready), 64'd1);
    tick();

    for (int i = 0; i < 4; i++) begin
      run_matrix(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort a matrix after three rows; the next row must land as row 0.
    send_rows(vecs[3], 3, "midrst");
    chk("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out_col", 64'(bus.out_col), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    run_matrix(vecs[0], "post_rst");

    // Two matrices offered back-to-back with the sink always ready.
    for (int k = 0; k < N; k++) begin
      exp_b2b[k]     = vecs[0].beats[k];
      exp_b2b[k + N] = vecs[3].beats[k];
    end
    stalls    = 0;
    first_cyc = -1;
    last_cyc  = -1;
    nb        = 0;
    fork
      begin
        int guard;
        for (int i = 0; i < 2 * N; i++) begin
          bus.in_valid = 1'b1;
          bus.in_row   = (i < N) ? vecs[0].rows[i] : vecs[3].rows[i - N];
          bus.tr_en    = 1'b1;
          guard = 0;
          while (!bus.in_ready && guard < 50) begin
            tick();
            guard++;
            stalls++;
          end
          tick();
        end
        bus.in_valid = 1'b0;
      end
      begin
        cyc = 0;
        while (nb < 2 * N && cyc < 200) begin
          if (bus.out_valid) begin
            chk($sformatf("b2b_beat%0d_col", nb), 64'(bus.out_col), 64'(exp_b2b[nb]));
            chk($sformatf("b2b_beat%0d_last", nb), 64'(bus.out_last), 64'((nb % N) == N - 1));
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            nb++;
          end
          tick();
          cyc++;
        end
      end
    join
    chk("b2b_beat_count", 64'(nb), 64'(2 * N));
    chk("b2b_in_stall_cycles", 64'(stalls), 64'(B2B_STALLS));
    chk("b2b_beat_span", 64'(last_cyc - first_cyc), 64'(B2B_SPAN));
    chk("b2b_busy_after", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
